// File: rtl/ialu_share_arb_if.sv
// Bundle of the two requester ports, the shared I-type ALU operand/result bus
// and the result register handshake used by ialu_share_arb.
interface ialu_share_arb_if #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_funct3;
  logic             req0_bit_th;
  logic [31:0]      req0_in1;
  logic [31:0]      req0_imm;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_funct3;
  logic             req1_bit_th;
  logic [31:0]      req1_in1;
  logic [31:0]      req1_imm;
  logic [TAG_W-1:0] req1_tag;

  logic [2:0]       alu_funct3;
  logic             alu_bit_th;
  logic [31:0]      alu_in1;
  logic [31:0]      alu_imm;
  logic [31:0]      alu_out;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;

  logic             flush;
  logic [CNT_W-1:0] stall_cnt;

  // Handshake: a transfer happens on a rising edge where valid && ready; a
  // requester keeps valid and its fields stable until that edge, and ready
  // never depends on anything the requester drives after the transfer.
  modport master (
    output req0_valid, req0_funct3, req0_bit_th, req0_in1, req0_imm, req0_tag,
    input  req0_ready,
    output req1_valid, req1_funct3, req1_bit_th, req1_in1, req1_imm, req1_tag,
    input  req1_ready,
    input  alu_funct3, alu_bit_th, alu_in1, alu_imm,
    output alu_out,
    input  rsp_valid, rsp_data, rsp_id, rsp_tag,
    output rsp_ready, flush,
    input  stall_cnt
  );

  modport slave (
    input  req0_valid, req0_funct3, req0_bit_th, req0_in1, req0_imm, req0_tag,
    output req0_ready,
    input  req1_valid, req1_funct3, req1_bit_th, req1_in1, req1_imm, req1_tag,
    output req1_ready,
    output alu_funct3, alu_bit_th, alu_in1, alu_imm,
    input  alu_out,
    output rsp_valid, rsp_data, rsp_id, rsp_tag,
    input  rsp_ready, flush,
    output stall_cnt
  );
endinterface

// File: rtl/ialu_share_arb.sv
// Round-robin arbiter sharing one I-type ALU between two requesters, with a
// one-entry tagged result register and a saturating stall counter.
module ialu_share_arb #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  ialu_share_arb_if.slave     bus,
  output logic                prio_o
);

  logic             prio_q, prio_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic any_valid;
  logic winner;
  logic can_issue;
  logic grant;
  logic ready0;
  logic ready1;
  logic stall_evt;

  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    // A lone valid port wins outright; the pointer only breaks ties.
    if (bus.req0_valid && bus.req1_valid) winner = prio_q;
    else                                  winner = bus.req1_valid;

    can_issue = (!rsp_valid_q || bus.rsp_ready) && !bus.flush;
    // rst_n gating keeps both readies low for the whole reset window.
    grant     = can_issue && any_valid && rst_n;
    ready0    = grant && !winner;
    ready1    = grant && winner;
    stall_evt = (bus.req0_valid && !ready0) || (bus.req1_valid && !ready1);
  end

  always_comb begin
    prio_d      = prio_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_tag_d   = rsp_tag_q;
    stall_d     = stall_q;

    if (bus.flush) begin
      rsp_valid_d = 1'b0;
    end else if (grant) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = bus.alu_out;
      rsp_id_d    = winner;
      rsp_tag_d   = winner ? bus.req1_tag : bus.req0_tag;
      prio_d      = !winner;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    if (stall_evt && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_id_q    <= 1'b0;
      rsp_tag_q   <= '0;
      stall_q     <= '0;
    end else begin
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_tag_q   <= rsp_tag_d;
      stall_q     <= stall_d;
    end
  end

  // Operands follow the winner even while the result register is blocked.
  always_comb begin
    bus.alu_funct3 = 3'd0;
    bus.alu_bit_th = 1'b0;
    bus.alu_in1    = 32'd0;
    bus.alu_imm    = 32'd0;
    if (any_valid) begin
      if (winner) begin
        bus.alu_funct3 = bus.req1_funct3;
        bus.alu_bit_th = bus.req1_bit_th;
        bus.alu_in1    = bus.req1_in1;
        bus.alu_imm    = bus.req1_imm;
      end else begin
        bus.alu_funct3 = bus.req0_funct3;
        bus.alu_bit_th = bus.req0_bit_th;
        bus.alu_in1    = bus.req0_in1;
        bus.alu_imm    = bus.req0_imm;
      end
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.stall_cnt  = stall_q;
  assign prio_o         = prio_q;

endmodule
